// File: rtl/elevator_pkg.sv
// Shared types for the elevator controller: FSM state encoding, travel direction
// and floor-mask helpers sized for the largest supported building.
package elevator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_MOVE_UP   = 2'b01,
        ST_MOVE_DOWN = 2'b10,
        ST_DOOR_OPEN = 2'b11
    } state_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam int MAX_FLOORS  = 16;
    localparam int MAX_FLOOR_W = 4;

    function automatic logic [MAX_FLOORS-1:0] above_mask(input logic [MAX_FLOOR_W-1:0] floor);
        logic [MAX_FLOORS-1:0] m;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            m[i] = (i > int'(floor));
        end
        return m;
    endfunction

    function automatic logic [MAX_FLOORS-1:0] below_mask(input logic [MAX_FLOORS-1:0] dummy_unused_guard,
                                                         input logic [MAX_FLOOR_W-1:0] floor);
        logic [MAX_FLOORS-1:0] m;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            m[i] = (i < int'(floor)) & dummy_unused_guard[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/elevator_timer.sv
// Down-counter shared by travel and door timing; expire flags the final cycle
// of the loaded interval.
module elevator_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/elevator_controller.sv
// Single-car elevator sequencer: latches floor calls, travels floor by floor and
// serves requests with a SCAN (keep going while work lies ahead) policy.
//
//   state        | meaning
//   -------------+-------------------------------------------------------
//   ST_IDLE      | parked, door shut, waiting for a pending request
//   ST_MOVE_UP   | travelling up, one floor per TRAVEL_CYCLES
//   ST_MOVE_DOWN | travelling down, one floor per TRAVEL_CYCLES
//   ST_DOOR_OPEN | door open at current_floor for DOOR_CYCLES after last hold
module elevator_controller
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6,
    localparam int FLOOR_W      = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  extra_waiting,
    output logic [1:0]            state_output,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int MAX_CYC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0]   TRAVEL_VAL = CNT_W'(TRAVEL_CYCLES);
    localparam logic [CNT_W-1:0]   DOOR_VAL   = CNT_W'(DOOR_CYCLES);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    state_e                state_q, state_d;
    dir_e                  dir_q, dir_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;

    logic                  tmr_load;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_expire;

    logic [MAX_FLOORS-1:0]  pend_ext;
    logic [MAX_FLOOR_W-1:0] floor_ext;
    logic                   any_above;
    logic                   any_below;
    logic                   go_up;
    logic                   go_down;
    logic                   door_hold;
    logic                   serve;
    logic [FLOOR_W-1:0]     serve_floor;
    logic [NUM_FLOORS-1:0]  latch;

    elevator_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    assign pend_ext  = MAX_FLOORS'(pending_q);
    assign floor_ext = MAX_FLOOR_W'(floor_q);
    assign any_above = |(pend_ext & above_mask(floor_ext));
    assign any_below = |below_mask(pend_ext, floor_ext);

    // Work ahead in the current direction wins; otherwise turn around.
    assign go_up     = any_above && ((dir_q == DIR_UP) || !any_below);
    assign go_down   = any_below && !go_up;
    assign door_hold = extra_waiting || call_req[floor_q];

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        floor_d     = floor_q;
        tmr_load    = 1'b0;
        tmr_val     = TRAVEL_VAL;
        serve       = 1'b0;
        serve_floor = floor_q;

        case (state_q)
            ST_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d  = ST_DOOR_OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_VAL;
                    serve    = 1'b1;
                end else if (go_up) begin
                    state_d  = ST_MOVE_UP;
                    dir_d    = DIR_UP;
                    tmr_load = 1'b1;
                end else if (go_down) begin
                    state_d  = ST_MOVE_DOWN;
                    dir_d    = DIR_DOWN;
                    tmr_load = 1'b1;
                end
            end
            ST_MOVE_UP: begin
                if (tmr_expire) begin
                    if (floor_q == TOP_FLOOR) begin
                        state_d = ST_IDLE;
                    end else begin
                        floor_d     = floor_q + 1'b1;
                        serve_floor = floor_d;
                        tmr_load    = 1'b1;
                        if (pending_q[floor_d]) begin
                            state_d = ST_DOOR_OPEN;
                            tmr_val = DOOR_VAL;
                            serve   = 1'b1;
                        end
                    end
                end
            end
            ST_MOVE_DOWN: begin
                if (tmr_expire) begin
                    if (floor_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        floor_d     = floor_q - 1'b1;
                        serve_floor = floor_d;
                        tmr_load    = 1'b1;
                        if (pending_q[floor_d]) begin
                            state_d = ST_DOOR_OPEN;
                            tmr_val = DOOR_VAL;
                            serve   = 1'b1;
                        end
                    end
                end
            end
            ST_DOOR_OPEN: begin
                if (door_hold) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_VAL;
                end else if (tmr_expire) begin
                    if (go_up) begin
                        state_d  = ST_MOVE_UP;
                        dir_d    = DIR_UP;
                        tmr_load = 1'b1;
                    end else if (go_down) begin
                        state_d  = ST_MOVE_DOWN;
                        dir_d    = DIR_DOWN;
                        tmr_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A call for the floor whose door is already open only extends the door.
        latch = call_req;
        if (state_q == ST_DOOR_OPEN) begin
            latch[floor_q] = 1'b0;
        end
        pending_d = pending_q | latch;
        if (serve) begin
            pending_d[serve_floor] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
        end
    end

    assign state_output  = state_q;
    assign current_floor = floor_q;
    assign door_open     = (state_q == ST_DOOR_OPEN);
    assign pending       = pending_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench: each scenario queues the hand-derived sequence of output
// changes (state, floor, pending, cycles since previous change); a monitor pops them.
module tb_elevator_controller;

    localparam int NF = 8;
    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] UP  = 2'b01;
    localparam logic [1:0] DN  = 2'b10;
    localparam logic [1:0] DR  = 2'b11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NF-1:0] call_req = '0;
    logic          extra_waiting = 1'b0;
    logic [1:0]    state_output;
    logic [2:0]    current_floor;
    logic          door_open;
    logic [NF-1:0] pending;

    elevator_controller #(
        .NUM_FLOORS    (8),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (6)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .call_req      (call_req),
        .extra_waiting (extra_waiting),
        .state_output  (state_output),
        .current_floor (current_floor),
        .door_open     (door_open),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic [2:0] fl;
        logic [7:0] pend;
        int         dwell;
    } ev_t;

    ev_t  exp_q[$];
    int   asserts = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_cyc = 0;
    logic [12:0] prev_obs = '0;

    task automatic check(input string name, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic ev(input logic [1:0] st, input logic [2:0] fl, input logic [7:0] pend, input int dwell);
        ev_t e;
        e.st = st;
        e.fl = fl;
        e.pend = pend;
        e.dwell = dwell;
        exp_q.push_back(e);
    endtask

    // Output-change monitor, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            prev_obs = '0;
            last_cyc = cyc;
        end else begin
            cyc++;
            if ({state_output, current_floor, pending} != prev_obs) begin
                if (exp_q.size() == 0) begin
                    asserts++;
                    fails++;
                    $display("FAIL unexpected_event: state %0d floor %0d pending %0h at cycle %0d, expected no change",
                             state_output, current_floor, pending, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("state", int'(state_output), int'(e.st));
                    check("floor", int'(current_floor), int'(e.fl));
                    check("pending", int'(pending), int'(e.pend));
                    check("door_open", int'(door_open), int'(e.st == DR));
                    if (e.dwell > 0) check("dwell", cyc - last_cyc, e.dwell);
                end
                prev_obs = {state_output, current_floor, pending};
                last_cyc = cyc;
            end
        end
    end

    // Asynchronous reset must take effect before any clock edge.
    initial forever begin
        @(negedge reset);
        #1;
        check("rst_state", int'(state_output), 0);
        check("rst_floor", int'(current_floor), 0);
        check("rst_door", int'(door_open), 0);
        check("rst_pending", int'(pending), 0);
    end

    task automatic do_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
    endtask

    task automatic pulse(input logic [7:0] m);
        @(posedge clk);
        #1 call_req = m;
        @(posedge clk);
        #1 call_req = '0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        asserts++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d events outstanding after %0d cycles, expected 0", exp_q.size(), budget);
            exp_q.delete();
        end
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // call to floor 3 from floor 0
        ev(IDL, 3'd0, 8'h08, 0);
        ev(UP,  3'd0, 8'h08, 1);
        ev(UP,  3'd1, 8'h08, 4);
        ev(UP,  3'd2, 8'h08, 4);
        ev(DR,  3'd3, 8'h00, 4);
        ev(IDL, 3'd3, 8'h00, 6);
        pulse(8'h08);
        drain(80);

        // call at the current floor, no movement
        do_reset();
        ev(IDL, 3'd0, 8'h01, 0);
        ev(DR,  3'd0, 8'h00, 1);
        ev(IDL, 3'd0, 8'h00, 6);
        pulse(8'h01);
        drain(80);

        // same-floor call while open reloads the door and does not latch
        ev(IDL, 3'd0, 8'h01, 0);
        ev(DR,  3'd0, 8'h00, 1);
        ev(IDL, 3'd0, 8'h00, 9);
        pulse(8'h01);
        repeat (2) @(posedge clk);
        pulse(8'h01);
        drain(80);

        // going to 5, floor 2 requested between 1 and 2
        ev(IDL, 3'd0, 8'h20, 0);
        ev(UP,  3'd0, 8'h20, 1);
        ev(UP,  3'd1, 8'h20, 4);
        ev(UP,  3'd1, 8'h24, 3);
        ev(DR,  3'd2, 8'h20, 1);
        ev(UP,  3'd2, 8'h20, 6);
        ev(UP,  3'd3, 8'h20, 4);
        ev(UP,  3'd4, 8'h20, 4);
        ev(DR,  3'd5, 8'h00, 4);
        ev(IDL, 3'd5, 8'h00, 6);
        pulse(8'h20);
        repeat (6) @(posedge clk);
        pulse(8'h04);
        drain(80);

        // door open at 4 heading up, calls at 6 and 1: 6 first
        do_reset();
        ev(IDL, 3'd0, 8'h10, 0);
        ev(UP,  3'd0, 8'h10, 1);
        ev(UP,  3'd1, 8'h10, 4);
        ev(UP,  3'd2, 8'h10, 4);
        ev(UP,  3'd3, 8'h10, 4);
        ev(DR,  3'd4, 8'h00, 4);
        ev(DR,  3'd4, 8'h42, 3);
        ev(UP,  3'd4, 8'h42, 3);
        ev(UP,  3'd5, 8'h42, 4);
        ev(DR,  3'd6, 8'h02, 4);
        ev(DN,  3'd6, 8'h02, 6);
        ev(DN,  3'd5, 8'h02, 4);
        ev(DN,  3'd4, 8'h02, 4);
        ev(DN,  3'd3, 8'h02, 4);
        ev(DN,  3'd2, 8'h02, 4);
        ev(DR,  3'd1, 8'h00, 4);
        ev(IDL, 3'd1, 8'h00, 6);
        pulse(8'h10);
        repeat (18) @(posedge clk);
        pulse(8'h42);
        drain(120);

        // door hold for 10 cycles gives 16 open cycles
        ev(IDL, 3'd1, 8'h02, 0);
        ev(DR,  3'd1, 8'h00, 1);
        ev(IDL, 3'd1, 8'h00, 16);
        pulse(8'h02);
        @(posedge clk);
        #1 extra_waiting = 1'b1;
        repeat (10) @(posedge clk);
        #1 extra_waiting = 1'b0;
        drain(80);

        // reset mid-travel at floor 2 heading for 7
        do_reset();
        ev(IDL, 3'd0, 8'h80, 0);
        ev(UP,  3'd0, 8'h80, 1);
        ev(UP,  3'd1, 8'h80, 4);
        ev(UP,  3'd2, 8'h80, 4);
        pulse(8'h80);
        repeat (10) @(posedge clk);
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/elevator_controller.md
ELEVATOR_CONTROLLER -- requirements
Module: elevator_controller

Interface
REQ-001 The block SHALL have the parameter NUM_FLOORS, default 8: number of floors served (2..16).
REQ-002 The block SHALL have the parameter TRAVEL_CYCLES, default 4: clock cycles to travel one floor (>=1).
REQ-003 The block SHALL have the parameter DOOR_CYCLES, default 6: clock cycles the door stays open (>=1).
REQ-004 The block SHALL have the local parameter FLOOR_W = $clog2(NUM_FLOORS).
REQ-005 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-007 Port call_req, input, NUM_FLOORS bits: bit i high in a cycle requests floor i.
REQ-008 Port extra_waiting, input, 1 bit: door hold; while high in DOOR_OPEN the door timer reloads.
REQ-009 Port state_output, output, 2 bits: FSM state (IDLE=00, MOVE_UP=01, MOVE_DOWN=10, DOOR_OPEN=11).
REQ-010 Port current_floor, output, FLOOR_W bits: floor the car is at or last passed.
REQ-011 Port door_open, output, 1 bit: high exactly when state_output==DOOR_OPEN.
REQ-012 Port pending, output, NUM_FLOORS bits: latched, unserved requests.

Function
REQ-013 A call_req bit sampled high at an edge SHALL set the matching pending bit at that edge; simultaneous bits SHALL all latch.
REQ-014 call_req for current_floor while in DOOR_OPEN SHALL NOT latch, and SHALL reload the door timer to DOOR_CYCLES.
REQ-015 In IDLE, a pending bit at current_floor SHALL move the car to DOOR_OPEN at the next edge and clear that bit.
REQ-016 In IDLE, with no pending bit at current_floor, any pending bit above SHALL select MOVE_UP, otherwise any below SHALL select MOVE_DOWN, at the next edge. If pending bits exist both above and below, the last travel direction SHALL win.
REQ-017 In MOVE_UP/MOVE_DOWN a travel counter SHALL count TRAVEL_CYCLES cycles; on the final cycle current_floor SHALL increment/decrement by 1 and the counter SHALL restart.
REQ-018 At the edge current_floor changes, if pending[new floor] is set, the state SHALL become DOOR_OPEN on that same edge, and the bit SHALL clear.
REQ-019 current_floor SHALL never exceed NUM_FLOORS-1 nor go below 0; MOVE_UP SHALL never be entered at the top floor, nor MOVE_DOWN at floor 0.
REQ-020 DOOR_OPEN SHALL last DOOR_CYCLES cycles after the last reload.
REQ-021 On door close the FSM SHALL continue in the last direction if pending bits lie beyond current_floor, else reverse if pending bits lie behind, else go to IDLE (SCAN policy).
REQ-022 A pending bit at a floor the car is currently between SHALL be served on arrival.
REQ-023 pending bits SHALL clear only on service (REQ-015/018) or reset.

Reset
REQ-024 While reset is low, all of the following SHALL hold asynchronously: state_output=IDLE, current_floor=0, door_open=0, pending=0, last direction=up, travel and door counters=0.
REQ-025 Reset asserted mid-travel or with the door open SHALL abandon the operation; requests are not retained.

Structure
REQ-026 The state encoding and the direction enum SHALL reside in the shared package elevator_pkg.
REQ-027 The travel/door cycle counter SHALL be the sub-module elevator_timer (load value, load, expire).

Verification (NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=6)
REQ-028 Reset released, call_req[3] pulsed one cycle -> the bench SHALL observe MOVE_UP for 12 cycles, current_floor 0->3, then DOOR_OPEN for 6 cycles, then IDLE with pending=0.
REQ-029 At floor 0 IDLE, call_req[0] -> the bench SHALL observe DOOR_OPEN at the next edge for 6 cycles, with no movement.
REQ-030 Car moving up from 0 to 5, call_req[2] while between 1 and 2 -> the bench SHALL observe a stop at 2 (6-cycle door), then continued travel to 5.
REQ-031 Car at 4 with the door open, pending[6] and pending[1] set, last direction up -> the bench SHALL observe service of 6 first, then 1.
REQ-032 DOOR_OPEN with extra_waiting held 10 cycles -> the bench SHALL observe door_open for 16 cycles in total.
REQ-033 Reset pulsed low mid-travel at floor 2 -> the bench SHALL observe all outputs return to their reset values immediately, without waiting for a clock edge.
